// File: rtl/led_anim_pkg.sv
// Shared types and the speed-select decode for the LED animation engine.
package led_anim_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // One-hot button to step multiplier; anything not strictly one-hot is the slowest rate.
    function automatic logic [2:0] speed_mult(input logic [4:0] buttons);
        case (buttons)
            5'b00001: return 3'd5;
            5'b00010: return 3'd4;
            5'b00100: return 3'd3;
            5'b01000: return 3'd2;
            5'b10000: return 3'd1;
            default:  return 3'd5;
        endcase
    endfunction

endpackage

// File: rtl/step_divider.sv
// Tick counter producing a one-cycle step enable every 'period' cycles while enabled.
module step_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        tick,
    output logic        step
);

    logic [31:0] cnt;

    // >= rather than == so a period shrunk below the current count wraps at once.
    assign tick = enable && (cnt >= (period - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            step <= 1'b1;
        end else begin
            cnt  <= cnt + 32'd1;
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/led_animator.sv
// LED pattern engine: chase/bounce/breathe animation state, duty map and one shared PWM counter.
module led_animator
    import led_anim_pkg::*;
#(
    parameter int NUM_LEDS  = 16,
    parameter int PWM_BITS  = 6,
    parameter int TICK_BASE = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          buttons,
    input  logic [1:0]          mode,
    input  logic                enable,
    output logic                step,
    output logic [NUM_LEDS-1:0] led
);

    localparam int                  POS_W = $clog2(NUM_LEDS);
    localparam logic [PWM_BITS-1:0] MAX   = {PWM_BITS{1'b1}};
    localparam logic [POS_W-1:0]    LAST  = POS_W'(NUM_LEDS - 1);

    logic [31:0]         period;
    logic                tick;
    mode_e               mode_q;
    logic                mode_change;
    logic [POS_W-1:0]    pos;
    logic [POS_W-1:0]    prev1;
    logic [POS_W-1:0]    prev2;
    dir_e                dir;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] pc;
    logic [PWM_BITS-1:0] duty [NUM_LEDS];

    assign period = 32'(TICK_BASE) * 32'(speed_mult(buttons));

    step_divider u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .period (period),
        .tick   (tick),
        .step   (step)
    );

    assign mode_change = (mode != mode_q);

    // A mode change restarts the pattern and takes priority over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
            pos    <= '0;
            dir    <= DIR_UP;
            level  <= '0;
        end else begin
            mode_q <= mode_e'(mode);
            if (mode_change) begin
                pos   <= '0;
                dir   <= DIR_UP;
                level <= '0;
            end else if (tick) begin
                case (mode_q)
                    MODE_CHASE: begin
                        pos <= (pos == LAST) ? '0 : pos + POS_W'(1);
                    end
                    MODE_BOUNCE: begin
                        if (dir == DIR_UP && pos == LAST) begin
                            dir <= DIR_DOWN;
                            pos <= LAST - POS_W'(1);
                        end else if (dir == DIR_DOWN && pos == '0) begin
                            dir <= DIR_UP;
                            pos <= POS_W'(1);
                        end else if (dir == DIR_UP) begin
                            pos <= pos + POS_W'(1);
                        end else begin
                            pos <= pos - POS_W'(1);
                        end
                    end
                    MODE_BREATHE: begin
                        if (dir == DIR_UP && level == MAX) begin
                            dir   <= DIR_DOWN;
                            level <= MAX - PWM_BITS'(1);
                        end else if (dir == DIR_DOWN && level == '0) begin
                            dir   <= DIR_UP;
                            level <= PWM_BITS'(1);
                        end else if (dir == DIR_UP) begin
                            level <= level + PWM_BITS'(1);
                        end else begin
                            level <= level - PWM_BITS'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign prev1 = (pos == '0) ? LAST : pos - POS_W'(1);
    assign prev2 = (prev1 == '0) ? LAST : prev1 - POS_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) duty[i] = '0;
        case (mode_q)
            MODE_CHASE: begin
                duty[prev2] = MAX >> 2;
                duty[prev1] = MAX >> 1;
                duty[pos]   = MAX;
            end
            MODE_BOUNCE: begin
                duty[pos] = MAX;
            end
            MODE_BREATHE: begin
                for (int i = 0; i < NUM_LEDS; i++) duty[i] = level;
            end
            default: begin
            end
        endcase
    end

    // pc never reaches MAX, so duty=MAX is solidly on and duty=0 solidly off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= '0;
            led <= '0;
        end else begin
            pc <= (pc == MAX - PWM_BITS'(1)) ? '0 : pc + PWM_BITS'(1);
            for (int i = 0; i < NUM_LEDS; i++) led[i] <= (duty[i] > pc);
        end
    end

endmodule
